mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares one single-ported unified instruction/data memory between two requesters:
//   - the fetch stage (read-only port, if_*)
//   - the MEM stage (read/write port, d_*)
//   Each requester holds its req until a one-cycle ack. The pipeline stalls on req & ~ack.
//   Data has priority, with a starvation guard for fetch. Sits between the pipeline registers and the memory.
// PARAMETERS
//   ADDR_W      32  address width, byte address, passed through unchanged
//   DATA_W      32  data width
//   MEM_LAT     1   memory read latency in cycles after the mem_en cycle; must be >= 1
//   STARVE_MAX  4   consecutive data grants with fetch pending before fetch is forced to win; >= 1
// PORTS
//   clk        in   1       clock, all logic on posedge
//   reset      in   1       synchronous, active-high
//   if_req     in   1       fetch read request
//   if_addr    in   ADDR_W  fetch address
//   if_ack     out  1       one-cycle pulse: if_rdata valid
//   if_rdata   out  DATA_W  fetch read data
//   d_req      in   1       data request
//   d_we       in   1       1 = write, 0 = read
//   d_addr     in   ADDR_W  data address
//   d_wdata    in   DATA_W  write data
//   d_ack      out  1       one-cycle pulse: access complete, d_rdata valid on reads
//   d_rdata    out  DATA_W  data read result
//   mem_en     out  1       memory access strobe, one cycle per transaction
//   mem_we     out  1       memory write enable, qualified by mem_en
//   mem_addr   out  ADDR_W  memory address
//   mem_wdata  out  DATA_W  memory write data
//   mem_rdata  in   DATA_W  memory read data, valid MEM_LAT cycles after mem_en
//   busy       out  1       high whenever state != IDLE
// BEHAVIOUR
//   - Reset values:
//     - all outputs 0; state IDLE; starve_cnt 0; latched addr/wdata/we/owner 0.
//     - Reset mid-transaction drops it: no ack, no further mem_en.
//   - FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//   - IDLE: on any req, pick winner and latch addr/we/wdata/owner -> ISSUE. No req: stay in IDLE.
//     - Arbitration when both req: d wins unless starve_cnt == STARVE_MAX, then if wins.
//   - ISSUE: mem_en=1 with latched mem_addr/mem_we/mem_wdata for exactly 1 cycle.
//   - WAIT: count MEM_LAT cycles; on the last one, register mem_rdata -> RESP.
//     - Register 0 instead for writes.
//   - RESP: owner's ack=1 for 1 cycle with registered rdata -> IDLE.
//   - Latency: req seen in IDLE at cycle t -> mem_en at t+1 -> ack at t+2+MEM_LAT.
//     MEM_LAT=1 gives ack at t+3.
//   - Throughput: one transaction per MEM_LAT+3 cycles. Requests are not pipelined.
//   - Back-to-back: req still high in the cycle after its ack is a new request, arbitrated in that IDLE cycle.
//   - Latched fields are used for the whole transaction. Req or addr changing after latch has no effect.
//     Req dropped before ack: the transaction still completes and ack still pulses.
//   - Read data: if_rdata/d_rdata hold their value between acks; updated only at their own ack.
//   - starve_cnt:
//     - +1 when d is granted while if_req=1, saturating at STARVE_MAX.
//     - cleared when if is granted.
//     - unchanged otherwise.
//   - Never both acks in one cycle. At most one mem_en per transaction.
// CONFIGURATION
//   ARB_PERF_EN defined:
//     - adds outputs perf_if_wait[31:0] and perf_d_wait[31:0].
//     - each counts cycles where its req=1 and its ack=0.
//     - wraps mod 2^32; cleared by reset.
//   ARB_PERF_EN undefined: those ports and counters do not exist. All other behaviour is identical.
// STRUCTURE
//   arb_pkg holds:
//     - state encoding ST_IDLE/ST_ISSUE/ST_WAIT/ST_RESP, 2 bits.
//     - owner encoding OWN_IF=0 / OWN_D=1.
//     - latency counter width: $clog2(MEM_LAT+1).
//   Sub-module mem_arb_pick: combinational winner select.
//     - inputs: if_req, d_req, starve_cnt.
//     - outputs: grant_valid, grant_owner.
//   FSM, latches and ack/rdata registers live in the top.
// TESTING
//   1. Reset, then if_req=1 if_addr=0x10, MEM_LAT=1, mem_rdata=0xDEADBEEF
//      -> mem_en @t+1 with mem_addr=0x10; if_ack=1, if_rdata=0xDEADBEEF @t+3.
//   2. if_req and d_req both 1 at t, d_we=1 d_addr=0x20 d_wdata=0x55
//      -> mem_we=1 mem_addr=0x20 @t+1; d_ack @t+3, then if serviced with if_ack @t+7.
//   3. d_req held high continuously with if_req=1, STARVE_MAX=4
//      -> 4 d_acks, then the 5th grant goes to if; starve_cnt returns to 0.
//   4. reset asserted in WAIT
//      -> no ack ever for that transaction; next cycle busy=0 and all outputs 0; a fresh req is served normally.
//   5. MEM_LAT=3, d read addr 0x8 -> mem_en @t+1, d_ack @t+5; d_rdata holds that value through a later if transaction.
//   6. ARB_PERF_EN defined, scenario 2 -> perf_d_wait=3, perf_if_wait=7.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and width helpers for the memory port arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    function automatic int unsigned lat_cnt_w(input int unsigned mem_lat);
        return $clog2(mem_lat + 1);
    endfunction

    function automatic int unsigned starve_cnt_w(input int unsigned starve_max);
        return $clog2(starve_max + 1);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select: data wins unless fetch has been starved STARVE_MAX times.
module mem_arb_pick
    import arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned CNT_W      = starve_cnt_w(STARVE_MAX)
) (
    input  logic             if_req,
    input  logic             d_req,
    input  logic [CNT_W-1:0] starve_cnt,
    output logic             grant_valid,
    output logic             grant_owner
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    always_comb begin
        grant_valid = if_req | d_req;
        grant_owner = OWN_IF;
        if (d_req && !(if_req && (starve_cnt == CNT_MAX)))
            grant_owner = OWN_D;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-ported memory shared by fetch (read-only) and data (read/write) requesters.
// Define ARB_PERF_EN to add perf_if_wait/perf_d_wait stall-cycle counters.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
`ifdef ARB_PERF_EN
    ,
    output logic [31:0]       perf_if_wait,
    output logic [31:0]       perf_d_wait
`endif
);

    localparam int unsigned LW = lat_cnt_w(MEM_LAT);
    localparam int unsigned SW = starve_cnt_w(STARVE_MAX);
    localparam logic [LW-1:0] LAT_LAST = LW'(MEM_LAT - 1);
    localparam logic [SW-1:0] SMAX     = SW'(STARVE_MAX);

    state_t            state;
    owner_t            lat_owner;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [LW-1:0]     lat_cnt;
    logic [SW-1:0]     starve_cnt;
    logic              grant_valid;
    logic              grant_owner;

    mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (SW)
    ) u_pick (
        .if_req      (if_req),
        .d_req       (d_req),
        .starve_cnt  (starve_cnt),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    // Address/wdata stay on the latched values; write strobe only counts with mem_en.
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign mem_we    = mem_en & lat_we;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            lat_owner  <= OWN_IF;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            mem_en     <= 1'b0;
            if_ack     <= 1'b0;
            d_ack      <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            busy       <= 1'b0;
        end else begin
            mem_en <= 1'b0;
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        if (grant_owner == OWN_D) begin
                            lat_owner <= OWN_D;
                            lat_we    <= d_we;
                            lat_addr  <= d_addr;
                            lat_wdata <= d_wdata;
                            if (if_req && (starve_cnt != SMAX))
                                starve_cnt <= starve_cnt + 1'b1;
                        end else begin
                            lat_owner  <= OWN_IF;
                            lat_we     <= 1'b0;
                            lat_addr   <= if_addr;
                            lat_wdata  <= '0;
                            starve_cnt <= '0;
                        end
                        mem_en <= 1'b1;
                        busy   <= 1'b1;
                        state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    lat_cnt <= '0;
                    state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (lat_cnt == LAT_LAST) begin
                        if (lat_owner == OWN_IF) begin
                            if_ack   <= 1'b1;
                            if_rdata <= mem_rdata;
                        end else begin
                            d_ack   <= 1'b1;
                            d_rdata <= lat_we ? '0 : mem_rdata;
                        end
                        state <= ST_RESP;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_if_wait <= '0;
            perf_d_wait  <= '0;
        end else begin
            if (if_req && !if_ack)
                perf_if_wait <= perf_if_wait + 32'd1;
            if (d_req && !d_ack)
                perf_d_wait <= perf_d_wait + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with MEM_LAT=1, one with MEM_LAT=3.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        if_req, if_ack, d_req, d_we, d_ack, mem_en, mem_we, busy;
    logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    logic        if3_req, if3_ack, d3_req, d3_we, d3_ack, mem3_en, mem3_we, busy3;
    logic [31:0] if3_addr, if3_rdata, d3_addr, d3_wdata, d3_rdata, mem3_addr, mem3_wdata, mem3_rdata;

`ifdef ARB_PERF_EN
    logic [31:0] perf_if_wait, perf_d_wait, perf3_if_wait, perf3_d_wait;
`endif

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u1 (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
`ifdef ARB_PERF_EN
        , .perf_if_wait(perf_if_wait), .perf_d_wait(perf_d_wait)
`endif
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) u3 (
        .clk(clk), .reset(reset),
        .if_req(if3_req), .if_addr(if3_addr), .if_ack(if3_ack), .if_rdata(if3_rdata),
        .d_req(d3_req), .d_we(d3_we), .d_addr(d3_addr), .d_wdata(d3_wdata),
        .d_ack(d3_ack), .d_rdata(d3_rdata),
        .mem_en(mem3_en), .mem_we(mem3_we), .mem_addr(mem3_addr), .mem_wdata(mem3_wdata),
        .mem_rdata(mem3_rdata), .busy(busy3)
`ifdef ARB_PERF_EN
        , .perf_if_wait(perf3_if_wait), .perf_d_wait(perf3_d_wait)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        if3_req = 0; if3_addr = '0; d3_req = 0; d3_we = 0; d3_addr = '0; d3_wdata = '0; mem3_rdata = '0;
        tick(); tick();
        chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_acks", {30'b0, if_ack, d_ack}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_busy3", {31'b0, busy3}, 32'd0);
        reset = 1'b0;
        tick();

        // 1: single fetch, MEM_LAT=1
        if_req = 1; if_addr = 32'h10; mem_rdata = 32'hFFFF_FFFF;
        tick();
        chk("s1_mem_en", {31'b0, mem_en}, 32'd1);
        chk("s1_mem_addr", mem_addr, 32'h10);
        chk("s1_mem_we", {31'b0, mem_we}, 32'd0);
        chk("s1_busy", {31'b0, busy}, 32'd1);
        tick();
        chk("s1_no_early_ack", {31'b0, if_ack}, 32'd0);
        chk("s1_single_mem_en", {31'b0, mem_en}, 32'd0);
        mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_rdata = 32'h0000_0000;
        chk("s1_if_ack", {31'b0, if_ack}, 32'd1);
        chk("s1_if_rdata", if_rdata, 32'hDEAD_BEEF);
        chk("s1_d_ack", {31'b0, d_ack}, 32'd0);
        if_req = 0;
        tick();
        chk("s1_ack_pulse", {31'b0, if_ack}, 32'd0);
        chk("s1_idle", {31'b0, busy}, 32'd0);
        chk("s1_rdata_hold", if_rdata, 32'hDEAD_BEEF);

        // 2: simultaneous requests, data write wins
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        if_req = 1; if_addr = 32'h30;
        d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'h55;
        tick();
        chk("s2_mem_en", {31'b0, mem_en}, 32'd1);
        chk("s2_mem_we", {31'b0, mem_we}, 32'd1);
        chk("s2_mem_addr", mem_addr, 32'h20);
        chk("s2_mem_wdata", mem_wdata, 32'h55);
        tick();
        tick();
        chk("s2_d_ack", {31'b0, d_ack}, 32'd1);
        chk("s2_if_ack_low", {31'b0, if_ack}, 32'd0);
        chk("s2_d_rdata_wr", d_rdata, 32'd0);
        d_req = 0; d_we = 0;
        tick();
        chk("s2_idle_gap", {31'b0, busy}, 32'd0);
        tick();
        chk("s2_if_mem_addr", mem_addr, 32'h30);
        chk("s2_if_mem_we", {31'b0, mem_we}, 32'd0);
        tick();
        mem_rdata = 32'h1234_5678;
        tick();
        chk("s2_if_ack", {31'b0, if_ack}, 32'd1);
        chk("s2_if_rdata", if_rdata, 32'h1234_5678);
        chk("s2_d_ack_low", {31'b0, d_ack}, 32'd0);
`ifdef ARB_PERF_EN
        chk("s2_perf_d_wait", perf_d_wait, 32'd3);
        chk("s2_perf_if_wait", perf_if_wait, 32'd7);
`endif
        if_req = 0;
        tick();

        // 3: starvation guard, d held with if pending
        if_req = 1; if_addr = 32'h40;
        d_req = 1; d_we = 0; d_addr = 32'h50;
        for (int k = 0; k < 6; k++) begin
            mem_rdata = 32'hA500_0000 | k;
            tick();
            chk($sformatf("s3_grant%0d_addr", k), mem_addr, (k == 4) ? 32'h40 : 32'h50);
            tick();
            tick();
            chk($sformatf("s3_ack%0d", k), {30'b0, if_ack, d_ack}, (k == 4) ? 32'd2 : 32'd1);
            if (k == 4) begin
                chk("s3_if_rdata", if_rdata, 32'hA500_0004);
                chk("s3_starve_clr", {29'b0, u1.starve_cnt}, 32'd0);
            end else begin
                chk($sformatf("s3_d_rdata%0d", k), d_rdata, 32'hA500_0000 | k);
            end
            if (k == 5) begin
                if_req = 0;
                d_req = 0;
            end
            tick();
        end

        // 4: reset in WAIT drops the transaction
        d_req = 1; d_we = 0; d_addr = 32'h60;
        tick();
        chk("s4_mem_en", {31'b0, mem_en}, 32'd1);
        tick();
        reset = 1'b1; d_req = 0;
        tick();
        chk("s4_busy", {31'b0, busy}, 32'd0);
        chk("s4_outs", {29'b0, mem_en, if_ack, d_ack}, 32'd0);
        chk("s4_d_rdata", d_rdata, 32'd0);
        chk("s4_if_rdata", if_rdata, 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("s4_quiet%0d", k), {29'b0, mem_en, if_ack, d_ack}, 32'd0);
        end
        if_req = 1; if_addr = 32'h70; mem_rdata = 32'hCAFE_F00D;
        tick();
        chk("s4_fresh_addr", mem_addr, 32'h70);
        tick();
        tick();
        chk("s4_fresh_ack", {31'b0, if_ack}, 32'd1);
        chk("s4_fresh_rdata", if_rdata, 32'hCAFE_F00D);
        if_req = 0;
        tick();

        // 5: MEM_LAT=3 data read, then fetch; d_rdata must hold
        d3_req = 1; d3_we = 0; d3_addr = 32'h8; mem3_rdata = 32'hFFFF_FFFF;
        tick();
        chk("s5_mem_en", {31'b0, mem3_en}, 32'd1);
        chk("s5_mem_addr", mem3_addr, 32'h8);
        tick();
        tick();
        tick();
        chk("s5_no_early_ack", {31'b0, d3_ack}, 32'd0);
        mem3_rdata = 32'h0BAD_F00D;
        tick();
        mem3_rdata = 32'hFFFF_FFFF;
        chk("s5_d_ack", {31'b0, d3_ack}, 32'd1);
        chk("s5_d_rdata", d3_rdata, 32'h0BAD_F00D);
        d3_req = 0;
        tick();
        chk("s5_ack_pulse", {31'b0, d3_ack}, 32'd0);
        if3_req = 1; if3_addr = 32'h100;
        tick();
        chk("s5_if_addr", mem3_addr, 32'h100);
        tick();
        tick();
        tick();
        mem3_rdata = 32'h1111_2222;
        tick();
        chk("s5_if_ack", {31'b0, if3_ack}, 32'd1);
        chk("s5_if_rdata", if3_rdata, 32'h1111_2222);
        chk("s5_d_rdata_hold", d3_rdata, 32'h0BAD_F00D);
        if3_req = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
